// File: rtl/dg_pc_pkg.sv
// Shared op encoding and the low-field LFSR successor for the PC sequencer.
package dg_pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_NEXT  = 3'd1,
    OP_JMP   = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_SETPG = 3'd5
  } op_e;

  // Successor of the low field: shift right, feedback XNOR of the two LSBs
  // lands in bit msb. Callers zero-extend into 32 bits and truncate back, so
  // one function serves any low-field width up to 32. All-ones maps to itself.
  function automatic logic [31:0] succ(input logic [31:0] low, input logic [4:0] msb);
    logic [31:0] r;
    r      = low >> 1;
    r[msb] = ~(low[0] ^ low[1]);
    return r;
  endfunction

endpackage

// File: rtl/dg_pc_sequencer_if.sv
// Op/target/page request bus and the PC/stack status returned by the sequencer.
interface dg_pc_sequencer_if #(
  parameter int PL_W        = 6,
  parameter int PU_W        = 4,
  parameter int STACK_DEPTH = 5
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [2:0]         op;
  logic [PL_W-1:0]    target;
  logic [PU_W-1:0]    page_in;
  logic               flags_clr;
  logic [PU_W+PL_W-1:0] pc;
  logic [DW-1:0]      depth;
  logic               stk_full;
  logic               stk_empty;
  logic               ovf;
  logic               unf;

  modport master (
    output op, target, page_in, flags_clr,
    input  pc, depth, stk_full, stk_empty, ovf, unf
  );

  modport slave (
    input  op, target, page_in, flags_clr,
    output pc, depth, stk_full, stk_empty, ovf, unf
  );
endinterface

// File: rtl/dg_ret_stack.sv
// Return-address LIFO. Entry 0 is the top; pushes shift toward the bottom so a
// push on a full stack drops the oldest entry without any extra logic.
module dg_ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 5,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  logic [W-1:0]  ent [DEPTH];
  logic [DW-1:0] depth_q;

  // Shift entries on push/pop; a pop on an empty stack is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      depth_q <= '0;
    end else if (push) begin
      ent[0] <= din;
      for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
      if (depth_q != FULL_CNT) depth_q <= depth_q + DW'(1);
    end else if (pop && depth_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
      ent[DEPTH-1] <= '0;
      depth_q      <= depth_q - DW'(1);
    end
  end

  assign dout  = ent[0];
  assign depth = depth_q;
  assign full  = (depth_q == FULL_CNT);
  assign empty = (depth_q == '0);
endmodule

// File: rtl/dg_pc_sequencer.sv
// Paged program counter: LFSR-stepped low field, pending-page jumps, call/return
// stack with sticky overflow/underflow flags. All outputs come from registers.
module dg_pc_sequencer
  import dg_pc_pkg::*;
#(
  parameter int              PL_W        = 6,
  parameter int              PU_W        = 4,
  parameter int              STACK_DEPTH = 5,
  parameter logic [PU_W-1:0] CALL_PAGE   = '1
) (
  input  logic            clk,
  input  logic            rst,
  dg_pc_sequencer_if.slave bus
);
  localparam int AW = PU_W + PL_W;
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [PU_W-1:0] page_q, pend_page_q;
  logic [PL_W-1:0] low_q;
  logic            pend_valid_q, ovf_q, unf_q;

  logic [PL_W-1:0] low_succ;
  logic [PU_W-1:0] jmp_page, call_page;
  logic            push, pop, ovf_set, unf_set;
  logic [AW-1:0]   stk_top;
  logic [DW-1:0]   stk_depth;
  logic            stk_full, stk_empty;

  // Op decode and next-address candidates.
  always_comb begin
    low_succ  = PL_W'(succ(32'(low_q), 5'(PL_W - 1)));
    jmp_page  = pend_valid_q ? pend_page_q : page_q;
    call_page = pend_valid_q ? pend_page_q : CALL_PAGE;
    push      = (bus.op == OP_CALL);
    pop       = (bus.op == OP_RET);
    ovf_set   = push && stk_full;
    unf_set   = pop && stk_empty;
  end

  dg_ret_stack #(.W(AW), .DEPTH(STACK_DEPTH)) u_stk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({page_q, low_succ}),
    .dout  (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // PC, pending page and sticky flag registers. A flag set this cycle wins
  // over flags_clr; HOLD and codes 6/7 leave the pending page armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q       <= '0;
      low_q        <= '0;
      pend_page_q  <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~bus.flags_clr);
      unf_q <= unf_set | (unf_q & ~bus.flags_clr);
      case (bus.op)
        OP_NEXT: begin
          low_q        <= low_succ;
          pend_valid_q <= 1'b0;
        end
        OP_JMP: begin
          page_q       <= jmp_page;
          low_q        <= bus.target;
          pend_valid_q <= 1'b0;
        end
        OP_CALL: begin
          page_q       <= call_page;
          low_q        <= bus.target;
          pend_valid_q <= 1'b0;
        end
        OP_RET: begin
          {page_q, low_q} <= stk_empty ? '0 : stk_top;
          pend_valid_q    <= 1'b0;
        end
        OP_SETPG: begin
          pend_page_q  <= bus.page_in;
          pend_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc        = {page_q, low_q};
  assign bus.depth     = stk_depth;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule

// File: doc/dg_pc_sequencer.md
DG_PC_SEQUENCER -- requirements
Module: dg_pc_sequencer

Interface
REQ-001 SHALL have parameter PL_W, default 6, width of the LFSR-counted low program-counter field.
REQ-002 SHALL have parameter PU_W, default 4, width of the page (upper) program-counter field.
REQ-003 SHALL have parameter STACK_DEPTH, default 5, number of return-address entries (range 1..16).
REQ-004 SHALL have parameter CALL_PAGE, default all ones (PU_W bits), page used by CALL when no page is pending.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port op, input, 3, operation code: HOLD=0, NEXT=1, JMP=2, CALL=3, RET=4, SETPG=5; codes 6 and 7 act as HOLD.
REQ-008 SHALL have port target, input, PL_W, low-field destination for JMP and CALL.
REQ-009 SHALL have port page_in, input, PU_W, page value captured by SETPG.
REQ-010 SHALL have port flags_clr, input, 1, clears the sticky ovf and unf flags.
REQ-011 SHALL have port pc, output, PU_W+PL_W, current address {page, low}.
REQ-012 SHALL have port depth, output, clog2(STACK_DEPTH+1), number of valid stack entries.
REQ-013 SHALL have ports stk_full and stk_empty, output, 1 each, meaning depth==STACK_DEPTH and depth==0.
REQ-014 SHALL have ports ovf and unf, output, 1 each, sticky overflow and underflow flags.

Function
REQ-015 succ(low) SHALL be {fb, low[PL_W-1:1]} with fb = ~(low[0]^low[1]); the page field never changes on a low-field step.
REQ-016 NEXT SHALL set low <= succ(low) in one cycle.
REQ-017 SETPG SHALL capture page_in into a pending-page register, set pend_valid, and leave pc unchanged.
REQ-018 JMP SHALL load pc <= {pend_valid ? pend_page : page, target}.
REQ-019 CALL SHALL push {page, succ(low)} and load pc <= {pend_valid ? pend_page : CALL_PAGE, target}.
REQ-020 RET SHALL pop the top entry into pc.
REQ-021 pend_valid SHALL clear on any op other than HOLD or SETPG; back-to-back SETPG SHALL keep the most recent page_in.
REQ-022 CALL when stk_full SHALL discard the oldest entry, push the new one, keep depth at STACK_DEPTH, and set ovf.
REQ-023 RET when stk_empty SHALL load pc <= 0, keep depth at 0, and set unf.
REQ-024 The LIFO SHALL preserve order: after k CALLs (k<=STACK_DEPTH), k RETs return addresses in reverse push order.
REQ-025 flags_clr SHALL clear ovf and unf, except that a flag set by the same cycle's op remains set.
REQ-026 All outputs SHALL be registered or decoded only from registers, with zero combinational path from op to pc.
REQ-027 A low value of all ones is a lock-up state of the recurrence; NEXT from it SHALL return all ones.

Reset
REQ-028 While rst is high, the block SHALL hold pc=0, depth=0, all stack entries=0, pend_valid=0, pend_page=0, ovf=0, unf=0, stk_empty=1, stk_full=0.
REQ-029 Assertion of rst mid-operation SHALL abort the current op immediately; the first op after deassertion SHALL act on the reset state.

Structure
REQ-030 The op code constants and their encoding SHALL live in a shared package dg_pc_pkg, together with the succ() function.
REQ-031 The return stack SHALL be a sub-module dg_ret_stack (parametrised width and depth) with push/pop/depth/full/empty; the sequencer SHALL own the flags.

Verification
REQ-032 The bench SHALL cover the NEXT chain: reset, then 6xNEXT (defaults) -> low 0x20, 0x30, 0x38, 0x3C, 0x3E, 0x1F; page stays 0.
REQ-033 The bench SHALL cover a paged jump: SETPG page_in=0x3, then JMP target=0x15 -> pc={0x3,0x15}; a following JMP target=0x01 -> pc={0x3,0x01}, since the page is already consumed.
REQ-034 The bench SHALL cover CALL/RET: at pc={0x2,0x20}, CALL target=0x07 -> pc={0xF,0x07}, depth=1; RET -> pc={0x2,0x30}, depth=0.
REQ-035 The bench SHALL cover overflow: 6 CALLs with distinct origins -> ovf=1, depth=5, stk_full=1; 5 RETs return the 2nd..6th pushes in reverse; a 6th RET -> pc=0, unf=1.
REQ-036 The bench SHALL cover flag collisions: flags_clr with RET-on-empty in the same cycle -> unf=1; flags_clr alone the next cycle -> unf=0, ovf=0.
REQ-037 The bench SHALL cover reset mid-sequence: assert rst between clock edges after 3 CALLs -> pc=0 and depth=0 immediately; RET after release -> unf=1.
